tx_arbiter_request_recorder_mp: RTL
===================================

Name: tx_arbiter_request_recorder_mp

Overview:
- Multi-port request recorder for the TX arbiter.
- Records the arrival order of transmit requests from up to NUM_SOURCES sources, including several requests arriving in the same cycle.
- Exposes the two oldest requests so the arbiter's selection state can send the head request, or bypass it with the second when ordering or flow-control rules block the head.
- Sits between the source request lines (A2P write, A2P read, master, RX-router cfg/err) and the arbiter FSM.

Parameters:
- NUM_SOURCES, 5: number of request sources. Request bit i maps to source code i+1; code 0 means NO_SOURCE.
- SRC_WIDTH, 3: width of a stored source code. Must satisfy 2^SRC_WIDTH > NUM_SOURCES.
- FIFO_DEPTH, 8: number of recorder entries. Must be ≥2.
- CNT_WIDTH, $clog2(FIFO_DEPTH+1): width of the occupancy count.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_SOURCES  per-source request for this cycle.
- req_ready  out  NUM_SOURCES  per-source acceptance; combinational.
- pop_first  in  1  remove the head entry (entry 0).
- pop_second  in  1  remove entry 1 (bypass pop).
- flush  in  1  discard all entries.
- head0_src  out  SRC_WIDTH  oldest entry; 0 when count<1.
- head1_src  out  SRC_WIDTH  second-oldest entry; 0 when count<2.
- count  out  CNT_WIDTH  current occupancy.
- empty  out  1  count==0.
- full  out  1  count==FIFO_DEPTH.
- pop_err  out  1  registered one-cycle pulse on an illegal pop.

Behaviour:
- Storage is a shift-register array entries[0..FIFO_DEPTH-1] plus a registered count. Entry 0 is the oldest.
- Reset (rst=1 at a clock edge): all entries=0, count=0, pop_err=0. Consequently head0/head1=0, empty=1, full=0.
- Reset takes priority over flush, pops and pushes. Any in-flight pushes or pops in that cycle are discarded.
- Free space: free = FIFO_DEPTH - count, computed from the registered count only. Same-cycle pops do not free space, so there is no combinational path from pop to req_ready.
- Push acceptance:
  - req_ready[i]=1 iff req_valid[i]=1 and the number of valid bits with index <i is < free.
  - Lowest index therefore wins when space is short.
  - req_ready=0 whenever flush=1.
- Push ordering: accepted sources are appended after the post-pop occupancy, in ascending index order, storing code i+1.
- Pop decode, applied before the append in the same cycle:
  - pop_first only, count≥1: shift entries 1.. down by 1; count-1.
  - pop_second only, count≥2: keep entry 0; shift entries 2.. down by 1; count-1.
  - Both, count≥2: shift down by 2; count-2.
- Illegal pops:
  - Cases: pop_first with count=0; pop_second with count<2; both with count<2.
  - The whole pop is ignored; no entry changes.
  - pop_err=1 on the next cycle for exactly one cycle.
  - A push in the same cycle still proceeds.
- Vacated entries are written 0.
- Next count = count - pops + accepted. Never exceeds FIFO_DEPTH, because acceptance is bounded by the pre-pop free space.
- flush=1 (rst=0): all entries=0 and count=0 next cycle. Pushes and pops that cycle are ignored; pop_err=0.
- Latency:
  - A request accepted in cycle N is visible on head0/head1/count in cycle N+1.
  - Pop effects are visible in N+1.
- Outputs head0_src, head1_src, empty and full are combinational decodes of registered state.
- Source codes are never duplicated by the block. A source re-asserting req_valid after acceptance records a new entry.

Test Plan:
- Reset: rst=1 for 2 cycles → count=0, empty=1, full=0, head0=0, head1=0, req_ready=0 with req_valid=0.
- Simultaneous push: empty, req_valid=5'b10101 → req_ready=5'b10101; next cycle count=3, head0=1, head1=3, entry2=5.
- Partial acceptance:
  - Setup: count=6 (depth 8), req_valid=5'b11111.
  - req_ready=5'b00011; next cycle count=8, full=1, entries[6..7]=1,2.
- Bypass pop: entries [1,3,5], pop_second=1 → next cycle count=2, head0=1, head1=5.
- Full with pop and push: count=8, pop_first=1, req_valid=5'b00100 → req_ready=0; next cycle count=7, old entry1 now head0.
- Illegal pop and flush:
  - Illegal pop: count=1, pop_second=1 → entries unchanged, pop_err=1 for one cycle.
  - Flush: then flush=1 with req_valid=5'b00001 → req_ready=0; next cycle count=0, empty=1.

Source files
------------

// File: rtl/tx_arbiter_request_recorder_mp.sv
// Multi-port request recorder for the TX arbiter.
// Records the arrival order of transmit requests from several sources, including several
// requests arriving in the same cycle. It exposes the two oldest entries so the arbiter can
// send the head request or bypass it with the second one.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous reset, active-high
//   req_valid  - per-source request; bit i records source code i+1
//   req_ready  - per-source acceptance (combinational, from registered occupancy only)
//   pop_first  - remove entry 0
//   pop_second - remove entry 1 (bypass pop)
//   flush      - discard all entries
//   head0_src  - oldest entry, 0 when empty
//   head1_src  - second-oldest entry, 0 when fewer than two entries
//   count      - current occupancy
//   empty      - count == 0
//   full       - count == FIFO_DEPTH
//   pop_err    - one-cycle registered pulse after an illegal pop
module tx_arbiter_request_recorder_mp #(
  parameter int unsigned NUM_SOURCES = 5,
  parameter int unsigned SRC_WIDTH   = 3,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CNT_WIDTH   = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SOURCES-1:0] req_valid,
  output logic [NUM_SOURCES-1:0] req_ready,
  input  logic                   pop_first,
  input  logic                   pop_second,
  input  logic                   flush,
  output logic [SRC_WIDTH-1:0]   head0_src,
  output logic [SRC_WIDTH-1:0]   head1_src,
  output logic [CNT_WIDTH-1:0]   count,
  output logic                   empty,
  output logic                   full,
  output logic                   pop_err
);

  localparam logic [CNT_WIDTH-1:0] DepthCnt = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CntOne   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CntTwo   = CNT_WIDTH'(2);

  logic [SRC_WIDTH-1:0] entries_q [FIFO_DEPTH];
  logic [SRC_WIDTH-1:0] entries_d [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH-1:0] free;
  logic                 pop_err_q, pop_err_d;

  // Free space uses the registered count only, so pops never reach req_ready.
  assign free = DepthCnt - count_q;

  // Lowest index wins: a request is accepted if fewer than 'free' requests sit below it.
  always_comb begin : accept_logic
    int unsigned ahead;
    ahead     = 0;
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (req_valid[i] && !flush && (ahead < 32'(free))) begin
        req_ready[i] = 1'b1;
      end
      if (req_valid[i]) begin
        ahead++;
      end
    end
  end

  always_comb begin : next_state
    int unsigned shift_amt;
    int unsigned sh;
    int unsigned wr_idx;
    logic        keep_head;
    logic [CNT_WIDTH-1:0] post_pop_cnt;
    logic [CNT_WIDTH-1:0] accepted;

    shift_amt    = 0;
    keep_head    = 1'b0;
    pop_err_d    = 1'b0;
    post_pop_cnt = count_q;
    accepted     = '0;

    // Pop decode; an illegal pop leaves all entries untouched.
    if (pop_first && pop_second) begin
      if (count_q >= CntTwo) begin
        shift_amt    = 2;
        post_pop_cnt = count_q - CntTwo;
      end else begin
        pop_err_d = 1'b1;
      end
    end else if (pop_first) begin
      if (count_q >= CntOne) begin
        shift_amt    = 1;
        post_pop_cnt = count_q - CntOne;
      end else begin
        pop_err_d = 1'b1;
      end
    end else if (pop_second) begin
      if (count_q >= CntTwo) begin
        shift_amt    = 1;
        keep_head    = 1'b1;
        post_pop_cnt = count_q - CntOne;
      end else begin
        pop_err_d = 1'b1;
      end
    end

    // Shift down; positions with no source entry are vacated to 0.
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      sh           = (keep_head && (k == 0)) ? 0 : shift_amt;
      entries_d[k] = '0;
      for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
        if (j == k + sh) begin
          entries_d[k] = entries_q[j];
        end
      end
    end

    // Append accepted sources after the post-pop occupancy in ascending index order.
    wr_idx = 32'(post_pop_cnt);
    for (int unsigned i = 0; i < NUM_SOURCES; i++) begin
      if (req_ready[i]) begin
        for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
          if (k == wr_idx) begin
            entries_d[k] = SRC_WIDTH'(i + 1);
          end
        end
        wr_idx++;
        accepted = accepted + CntOne;
      end
    end
    count_d = post_pop_cnt + accepted;

    if (flush) begin
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        entries_d[k] = '0;
      end
      count_d   = '0;
      pop_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        entries_q[k] <= '0;
      end
      count_q   <= '0;
      pop_err_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        entries_q[k] <= entries_d[k];
      end
      count_q   <= count_d;
      pop_err_q <= pop_err_d;
    end
  end

  assign head0_src = (count_q >= CntOne) ? entries_q[0] : '0;
  assign head1_src = (count_q >= CntTwo) ? entries_q[1] : '0;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DepthCnt);
  assign pop_err   = pop_err_q;

endmodule
